// File: rtl/k_means_apb_master.sv
`default_nettype none
// ============================================================================
// Module   : k_means_apb_master
// Purpose  : Command/response to APB3 initiator for the k-means accelerator,
//            with a wait-for-interrupt command.
// Revision : 1.0 - initial release
// ============================================================================
module k_means_apb_master #(
  parameter int addrWidth         = 9,
  parameter int dataWidth         = 91,
  parameter int timeout_cycles    = 200,
  parameter int irq_timeout_width = 16,
  parameter int irq_timeout       = 0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 cmd_valid,
  output logic                 cmd_ready,
  input  logic [1:0]           cmd_op,
  input  logic [addrWidth-1:0] cmd_addr,
  input  logic [dataWidth-1:0] cmd_wdata,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [dataWidth-1:0] rsp_rdata,
  output logic                 rsp_err,
  output logic                 busy,
  output logic [addrWidth-1:0] paddr,
  output logic                 pwrite,
  output logic                 psel,
  output logic                 penable,
  output logic [dataWidth-1:0] pwdata,
  input  logic [dataWidth-1:0] prdata,
  input  logic                 pready,
  input  logic                 interupt
);

  localparam int c_ACC_W = (timeout_cycles > 1) ? $clog2(timeout_cycles) : 1;
  localparam logic [c_ACC_W-1:0]           c_ACC_LAST = c_ACC_W'(timeout_cycles - 1);
  localparam logic [irq_timeout_width-1:0] c_IRQ_LAST = irq_timeout_width'(irq_timeout - 1);
  localparam logic [1:0] c_OP_READ  = 2'b00;
  localparam logic [1:0] c_OP_WRITE = 2'b01;
  localparam logic [1:0] c_OP_WAIT  = 2'b10;

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_SETUP    = 3'd1,
    S_ACCESS   = 3'd2,
    S_WAIT_IRQ = 3'd3,
    S_RESP     = 3'd4
  } state_t;

  state_t                 r_state, w_state;
  logic                   r_cmd_ready, w_cmd_ready;
  logic                   r_rsp_valid, w_rsp_valid;
  logic [dataWidth-1:0]   r_rsp_rdata, w_rsp_rdata;
  logic                   r_rsp_err,   w_rsp_err;
  logic                   r_busy,      w_busy;
  logic [addrWidth-1:0]   r_paddr,     w_paddr;
  logic                   r_pwrite,    w_pwrite;
  logic                   r_psel,      w_psel;
  logic                   r_penable,   w_penable;
  logic [dataWidth-1:0]   r_pwdata,    w_pwdata;
  logic [c_ACC_W-1:0]     r_acc_cnt,   w_acc_cnt;
  logic [irq_timeout_width-1:0] r_irq_cnt, w_irq_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_cmd_ready <= 1'b0;
      r_rsp_valid <= 1'b0;
      r_rsp_rdata <= '0;
      r_rsp_err   <= 1'b0;
      r_busy      <= 1'b0;
      r_paddr     <= '0;
      r_pwrite    <= 1'b0;
      r_psel      <= 1'b0;
      r_penable   <= 1'b0;
      r_pwdata    <= '0;
      r_acc_cnt   <= '0;
      r_irq_cnt   <= '0;
    end else begin
      r_state     <= w_state;
      r_cmd_ready <= w_cmd_ready;
      r_rsp_valid <= w_rsp_valid;
      r_rsp_rdata <= w_rsp_rdata;
      r_rsp_err   <= w_rsp_err;
      r_busy      <= w_busy;
      r_paddr     <= w_paddr;
      r_pwrite    <= w_pwrite;
      r_psel      <= w_psel;
      r_penable   <= w_penable;
      r_pwdata    <= w_pwdata;
      r_acc_cnt   <= w_acc_cnt;
      r_irq_cnt   <= w_irq_cnt;
    end
  end

  always_comb begin
    w_state     = r_state;
    w_paddr     = r_paddr;
    w_pwrite    = r_pwrite;
    w_pwdata    = r_pwdata;
    w_rsp_rdata = r_rsp_rdata;
    w_rsp_err   = r_rsp_err;
    w_acc_cnt   = r_acc_cnt;
    w_irq_cnt   = r_irq_cnt;

    case (r_state)
      S_IDLE: begin
        if (cmd_valid && r_cmd_ready) begin
          case (cmd_op)
            c_OP_READ, c_OP_WRITE: begin
              w_paddr  = cmd_addr;
              w_pwdata = cmd_wdata;
              w_pwrite = (cmd_op == c_OP_WRITE);
              w_state  = S_SETUP;
            end
            c_OP_WAIT: begin
              w_irq_cnt = '0;
              w_state   = S_WAIT_IRQ;
            end
            default: begin
              w_rsp_err   = 1'b1;
              w_rsp_rdata = '0;
              w_state     = S_RESP;
            end
          endcase
        end
      end
      S_SETUP: begin
        w_acc_cnt = '0;
        w_state   = S_ACCESS;
      end
      S_ACCESS: begin
        // A ready slave in the last allowed cycle still completes normally.
        if (pready) begin
          w_rsp_rdata = r_pwrite ? '0 : prdata;
          w_rsp_err   = 1'b0;
          w_state     = S_RESP;
        end else if (r_acc_cnt == c_ACC_LAST) begin
          w_rsp_rdata = '0;
          w_rsp_err   = 1'b1;
          w_state     = S_RESP;
        end else begin
          w_acc_cnt = r_acc_cnt + c_ACC_W'(1);
        end
      end
      S_WAIT_IRQ: begin
        if (interupt) begin
          w_rsp_rdata = '0;
          w_rsp_err   = 1'b0;
          w_state     = S_RESP;
        end else if ((irq_timeout != 0) && (r_irq_cnt == c_IRQ_LAST)) begin
          w_rsp_rdata = '0;
          w_rsp_err   = 1'b1;
          w_state     = S_RESP;
        end else begin
          w_irq_cnt = r_irq_cnt + irq_timeout_width'(1);
        end
      end
      S_RESP: begin
        if (rsp_ready) begin
          w_state = S_IDLE;
        end
      end
      default: begin
        w_state = S_IDLE;
      end
    endcase

    // Flags are registered from the next state so they line up with it.
    w_cmd_ready = (w_state == S_IDLE);
    w_rsp_valid = (w_state == S_RESP);
    w_busy      = (w_state != S_IDLE);
    w_psel      = (w_state == S_SETUP) || (w_state == S_ACCESS);
    w_penable   = (w_state == S_ACCESS);
  end

  assign cmd_ready = r_cmd_ready;
  assign rsp_valid = r_rsp_valid;
  assign rsp_rdata = r_rsp_rdata;
  assign rsp_err   = r_rsp_err;
  assign busy      = r_busy;
  assign paddr     = r_paddr;
  assign pwrite    = r_pwrite;
  assign psel      = r_psel;
  assign penable   = r_penable;
  assign pwdata    = r_pwdata;

endmodule
`default_nettype wire

// File: tb/tb_k_means_apb_master.sv
`default_nettype none
// ============================================================================
// Module   : tb_k_means_apb_master
// Purpose  : Randomized self-checking bench with an APB memory slave and a
//            transaction-level reference model of latency and responses.
// Revision : 1.0 - initial release
// ============================================================================
module tb_k_means_apb_master;

  localparam int AW  = 9;
  localparam int DW  = 91;
  localparam int TO  = 4;
  localparam int ITO = 5;

  logic          clk = 1'b0;
  logic          rst;
  logic          cmd_valid, cmd_ready;
  logic [1:0]    cmd_op;
  logic [AW-1:0] cmd_addr;
  logic [DW-1:0] cmd_wdata;
  logic          rsp_valid, rsp_ready;
  logic [DW-1:0] rsp_rdata;
  logic          rsp_err, busy;
  logic [AW-1:0] paddr;
  logic          pwrite, psel, penable;
  logic [DW-1:0] pwdata, prdata;
  logic          pready, interupt;

  always #5 clk = ~clk;

  k_means_apb_master #(
    .addrWidth(AW), .dataWidth(DW), .timeout_cycles(TO),
    .irq_timeout_width(16), .irq_timeout(ITO)
  ) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .rsp_err(rsp_err), .busy(busy),
    .paddr(paddr), .pwrite(pwrite), .psel(psel), .penable(penable),
    .pwdata(pwdata), .prdata(prdata), .pready(pready), .interupt(interupt)
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  function automatic logic [DW-1:0] rnd_data();
    logic [95:0] t;
    t = {$urandom, $urandom, $urandom};
    return t[DW-1:0];
  endfunction

  // APB slave: memory that inserts slv_wait wait states per transfer.
  logic [DW-1:0] slv_mem [int];
  int slv_wait = 0;
  int slv_k    = 0;
  always @(negedge clk) begin
    if (psel && penable) begin
      if (slv_k == slv_wait) begin
        pready = 1'b1;
        if (pwrite) slv_mem[int'(paddr)] = pwdata;
        prdata = slv_mem.exists(int'(paddr)) ? slv_mem[int'(paddr)] : '0;
      end else begin
        pready = 1'b0;
        prdata = rnd_data();
      end
      slv_k++;
    end else begin
      slv_k  = 0;
      pready = 1'($urandom_range(0, 1));
      prdata = rnd_data();
    end
  end

  logic [DW-1:0] model_mem [int];

  // Issue one command from a negedge; returns at the negedge after the rsp handshake.
  task automatic run_cmd(input logic [1:0] op, input logic [AW-1:0] addr,
                         input logic [DW-1:0] wd, input int w, input int d, input int bp);
    int exp_lat, lat, n;
    logic exp_err;
    logic [DW-1:0] exp_rd;
    bit apb;
    apb = (op == 2'b00) || (op == 2'b01);
    exp_rd = '0;
    case (op)
      2'b00: begin
        exp_err = (w >= TO);
        exp_lat = exp_err ? 2 + TO : 3 + w;
        if (!exp_err && model_mem.exists(int'(addr))) exp_rd = model_mem[int'(addr)];
      end
      2'b01: begin
        exp_err = (w >= TO);
        exp_lat = exp_err ? 2 + TO : 3 + w;
        if (!exp_err) model_mem[int'(addr)] = wd;
      end
      2'b10: begin
        exp_err = (d >= ITO);
        exp_lat = exp_err ? 1 + ITO : 2 + d;
      end
      default: begin
        exp_err = 1'b1;
        exp_lat = 1;
      end
    endcase

    slv_wait  = w;
    rsp_ready = 1'b0;
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_addr  = addr;
    cmd_wdata = wd;
    n = 0;
    while (!cmd_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!cmd_ready) chk("accept", {127'd0, cmd_ready}, 128'd1);
    @(posedge clk);
    @(negedge clk);
    cmd_valid = 1'b0;
    cmd_op    = 2'($urandom_range(0, 3));
    cmd_addr  = AW'($urandom);
    cmd_wdata = rnd_data();
    lat = 1;
    while (!rsp_valid && lat < 40) begin
      chk("busy", {127'd0, busy}, 128'd1);
      chk("cmd_ready_busy", {127'd0, cmd_ready}, 128'd0);
      if (apb) begin
        chk("psel", {127'd0, psel}, 128'd1);
        chk("penable", {127'd0, penable}, {127'd0, lat >= 2});
        chk("paddr", {119'd0, paddr}, {119'd0, addr});
        chk("pwrite", {127'd0, pwrite}, {127'd0, op == 2'b01});
        if (op == 2'b01) chk("pwdata", {37'd0, pwdata}, {37'd0, wd});
      end else begin
        chk("psel_idle", {126'd0, psel, penable}, 128'd0);
      end
      interupt = (op == 2'b10) ? (lat >= 1 + d) : 1'($urandom_range(0, 1));
      @(negedge clk);
      lat++;
    end
    chk("rsp_latency", 128'(lat), 128'(exp_lat));
    chk("rsp_err", {127'd0, rsp_err}, {127'd0, exp_err});
    chk("rsp_rdata", {37'd0, rsp_rdata}, {37'd0, exp_rd});
    chk("psel_resp", {126'd0, psel, penable}, 128'd0);
    if (apb) chk("paddr_hold", {119'd0, paddr}, {119'd0, addr});

    // Backpressure with a competing command presented.
    interupt  = 1'($urandom_range(0, 1));
    cmd_valid = (bp > 0);
    for (int i = 0; i < bp; i++) begin
      @(negedge clk);
      chk("bp_valid", {127'd0, rsp_valid}, 128'd1);
      chk("bp_rdata", {37'd0, rsp_rdata}, {37'd0, exp_rd});
      chk("bp_err", {127'd0, rsp_err}, {127'd0, exp_err});
      chk("bp_cmd_ready", {127'd0, cmd_ready}, 128'd0);
    end
    cmd_valid = 1'b0;
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    chk("rsp_drop", {127'd0, rsp_valid}, 128'd0);
    chk("cmd_ready_next", {127'd0, cmd_ready}, 128'd1);
    chk("busy_idle", {127'd0, busy}, 128'd0);
  endtask

  logic [AW-1:0] addr_pool [8];

  initial begin
    rst       = 1'b1;
    cmd_valid = 1'b0;
    cmd_op    = 2'b00;
    cmd_addr  = '0;
    cmd_wdata = '0;
    rsp_ready = 1'b0;
    interupt  = 1'b0;
    for (int i = 0; i < 8; i++) addr_pool[i] = AW'(i * 4);

    repeat (2) @(negedge clk);
    chk("rst_cmd_ready", {127'd0, cmd_ready}, 128'd0);
    chk("rst_flags", {123'd0, rsp_valid, rsp_err, busy, psel, penable}, 128'd0);
    chk("rst_rdata", {37'd0, rsp_rdata}, 128'd0);
    chk("rst_apb", {37'd0, pwdata ^ {82'd0, paddr}}, 128'd0);
    chk("rst_pwrite", {127'd0, pwrite}, 128'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_cmd_ready", {127'd0, cmd_ready}, 128'd1);

    // Directed cases from the plan
    run_cmd(2'b01, 9'h004, 91'h1234, 0, 0, 0);
    run_cmd(2'b01, 9'h010, 91'hABC, 1, 0, 0);
    run_cmd(2'b00, 9'h010, '0, 3, 0, 6);
    run_cmd(2'b00, 9'h004, '0, 4, 0, 0);
    run_cmd(2'b00, 9'h004, '0, 3, 0, 0);
    run_cmd(2'b10, '0, '0, 0, 0, 0);
    run_cmd(2'b10, '0, '0, 0, 4, 0);
    run_cmd(2'b10, '0, '0, 0, 9, 0);
    run_cmd(2'b11, '0, '0, 0, 0, 1);

    // Reset during ACCESS
    slv_wait  = 100;
    cmd_valid = 1'b1;
    cmd_op    = 2'b00;
    cmd_addr  = 9'h008;
    interupt  = 1'b0;
    @(posedge clk);
    @(negedge clk);
    cmd_valid = 1'b0;
    @(negedge clk);
    chk("mid_access_penable", {127'd0, penable}, 128'd1);
    #2 rst = 1'b1;
    #1 chk("async_rst_apb", {126'd0, psel, penable}, 128'd0);
    chk("async_rst_rsp", {126'd0, rsp_valid, busy}, 128'd0);
    @(negedge clk);
    rst = 1'b0;
    repeat (4) begin
      @(negedge clk);
      chk("post_rst_quiet", {126'd0, rsp_valid, psel}, 128'd0);
    end
    run_cmd(2'b11, '0, '0, 0, 0, 0);

    // Randomized traffic
    for (int t = 0; t < 80; t++) begin
      logic [1:0] op;
      int r;
      r  = $urandom_range(0, 9);
      op = (r < 4) ? 2'b01 : (r < 7) ? 2'b00 : (r < 9) ? 2'b10 : 2'b11;
      run_cmd(op, addr_pool[$urandom_range(0, 7)], rnd_data(),
              $urandom_range(0, 5), $urandom_range(0, 7), $urandom_range(0, 3));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/k_means_apb_master.md
# k_means_apb_master

APB initiator that drives the k-means accelerator's register file from a simple command/response interface. It turns one queued command into one APB3 read or write transfer, or into a wait-for-interrupt. It returns read data and an error flag per command, and sits on the same APB bus and address map as the accelerator, on the initiator side. Firmware models and system benches use it to load points and centroids, start the core, await completion and read results back.

## Interface
Parameters:
- addrWidth, 9, APB address width
- dataWidth, 91, APB data width
- timeout_cycles, 200, maximum ACCESS-phase cycles before abort (≥1)
- irq_timeout_width, 16, width of the interrupt-wait counter
- irq_timeout, 0, maximum WAIT_IRQ cycles; 0 = wait forever

Ports:
- clk  in  1  clock; all logic on rising edge
- rst  in  1  reset, asynchronous, active-high
- cmd_valid  in  1  command present
- cmd_ready  out  1  block accepts a command this cycle
- cmd_op  in  2  00 read, 01 write, 10 wait-for-interrupt, 11 reserved
- cmd_addr  in  addrWidth  APB address
- cmd_wdata  in  dataWidth  write data
- rsp_valid  out  1  response present
- rsp_ready  in  1  consumer accepts response
- rsp_rdata  out  dataWidth  read data; 0 for write, wait and error
- rsp_err  out  1  command failed (timeout or reserved op)
- busy  out  1  state ≠ IDLE
- paddr  out  addrWidth  APB address
- pwrite  out  1  APB direction
- psel  out  1  APB select
- penable  out  1  APB enable
- pwdata  out  dataWidth  APB write data
- prdata  in  dataWidth  APB read data
- pready  in  1  APB ready
- interupt  in  1  accelerator completion interrupt, level-sensitive

## Operation
- States: IDLE, SETUP, ACCESS, WAIT_IRQ, RESP. All outputs are registered.
- IDLE: cmd_ready=1. A handshake (cmd_valid & cmd_ready) transitions as follows:
  - read/write: latch addr, wdata and direction into paddr, pwdata and pwrite; go to SETUP.
  - wait: clear the irq counter; go to WAIT_IRQ.
  - reserved: go to RESP with rsp_err=1, rsp_rdata=0; no APB activity.
- SETUP: psel=1, penable=0 for exactly one cycle, then ACCESS.
- ACCESS: psel=1, penable=1; paddr, pwrite and pwdata stay stable.
  - pready=1: capture prdata into rsp_rdata (reads) or 0 (writes); rsp_err=0; go to RESP.
  - Timeout: the access cycle counter starts at 0 on entry. If the count reaches timeout_cycles-1 with pready=0, go to RESP with rsp_err=1, rsp_rdata=0.
  - pready=1 in the final allowed cycle wins over timeout.
- WAIT_IRQ: no APB activity.
  - interupt=1: go to RESP with rsp_err=0.
  - irq_timeout≠0 and the counter reaches irq_timeout-1 with interupt=0: go to RESP with rsp_err=1.
  - interupt wins on a tie.
- RESP: rsp_valid=1; rsp_rdata and rsp_err stable. On rsp_ready go to IDLE and drop rsp_valid.
- Outside SETUP/ACCESS: psel=0, penable=0; paddr, pwrite and pwdata hold their last values.
- Only one command is in flight; no command buffering.

## Timing
- Reset values: cmd_ready=0 while rst is asserted and 1 in the first cycle after release. rsp_valid=0, rsp_rdata=0, rsp_err=0, busy=0, psel=0, penable=0, paddr=0, pwrite=0, pwdata=0.
- Zero-wait APB transfer:
  - cycle 0: command accepted.
  - cycle 1: SETUP.
  - cycle 2: ACCESS, pready=1.
  - cycle 3: rsp_valid=1.
- Each pready=0 cycle in ACCESS adds one cycle of latency.
- Wait command with interupt already high: accept at cycle 0, WAIT_IRQ at cycle 1, rsp_valid at cycle 2.
- Reserved op: rsp_valid in the cycle after acceptance.
- Back-to-back commands: the rsp handshake happens in cycle N, the next command is accepted in cycle N+1. Minimum command period is 4 cycles for APB ops.
- rsp_valid holds indefinitely under rsp_ready=0; no new command is accepted meanwhile.
- Reset asserted mid-transfer: psel and penable drop asynchronously, the pending response is discarded, and the state returns to IDLE.
- pready and prdata are ignored outside ACCESS. interupt is ignored outside WAIT_IRQ.

## Test plan
- Write, addr=0x004, wdata=0x1234, zero-wait slave: psel at cycle 1, penable at cycle 2, pwrite=1, pwdata=0x1234. rsp_valid at cycle 3 with rsp_err=0, rsp_rdata=0.
- Read, addr=0x010, slave holds pready=0 for 3 ACCESS cycles and then returns prdata=0xABC: penable high for 4 cycles with paddr stable; rsp_rdata=0xABC, rsp_err=0.
- Read with timeout_cycles=4 and pready stuck at 0: ACCESS lasts exactly 4 cycles, psel drops, rsp_err=1, rsp_rdata=0. Repeat with pready=1 in the 4th cycle: success.
- Wait command with irq_timeout=0 and interupt raised 10 cycles after acceptance: no psel activity, rsp_valid the cycle after interupt is sampled, rsp_err=0. With irq_timeout=5 and no interupt: rsp_err=1 after 5 WAIT_IRQ cycles.
- Backpressure: rsp_ready=0 for 6 cycles after a read: rsp_valid and rsp_rdata stable, cmd_ready=0 with cmd_valid held. The next command is accepted the cycle after the rsp handshake.
- rst pulsed during ACCESS: psel and penable are 0 immediately and no rsp_valid follows. A reserved op (11) afterwards gets rsp_err=1 one cycle after acceptance, with psel never asserted.
